// File: rtl/conv_window_gen.sv
// Streaming sliding-window generator: buffers KERNEL-1 image lines and emits every
// valid KERNEL x KERNEL window, packed for the conv stage, one cycle after its last pixel.
module conv_window_gen #(
  parameter int KERNEL = 3,
  parameter int N      = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               pix_in,
  input  logic                       en_in,
  input  logic                       sof,
  output logic [KERNEL*KERNEL*N-1:0] data2conv,
  output logic                       en_out,
  output logic                       frame_end
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0]              col;
  logic [CW-1:0]              cur_col;
  logic [RW-1:0]              row;
  logic [RW-1:0]              cur_row;
  logic                       at_line_end;
  logic                       at_frame_end;
  logic                       win_valid;
  logic                       valid_q;
  logic                       last_q;
  logic [N-1:0]               col_data [KERNEL];
  logic [N-1:0]               win      [KERNEL][KERNEL];
  logic [KERNEL*KERNEL*N-1:0] win_flat;

  // sof re-anchors the pixel being accepted at (0,0); the valid rule keys off that position
  always_comb begin
    cur_col      = sof ? '0 : col;
    cur_row      = sof ? '0 : row;
    at_line_end  = (int'(cur_col) == IMG_W - 1);
    at_frame_end = at_line_end && (int'(cur_row) == IMG_H - 1);
    win_valid    = en_in && (int'(cur_col) >= KERNEL - 1) && (int'(cur_row) >= KERNEL - 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (en_in) begin
      if (at_line_end) begin
        col <= '0;
        row <= at_frame_end ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  generate
    if (KERNEL > 1) begin : g_line_buf
      // line_buf[0] holds the previous line, higher indices hold progressively older lines
      logic [N-1:0] line_buf [KERNEL-1][IMG_W];

      always_ff @(posedge clk) begin
        if (en_in) begin
          line_buf[0][cur_col] <= pix_in;
          for (int j = 1; j < KERNEL - 1; j++) begin
            line_buf[j][cur_col] <= line_buf[j-1][cur_col];
          end
        end
      end

      always_comb begin
        for (int r = 0; r < KERNEL - 1; r++) begin
          col_data[r] = line_buf[KERNEL-2-r][cur_col];
        end
        col_data[KERNEL-1] = pix_in;
      end
    end else begin : g_no_line_buf
      always_comb col_data[0] = pix_in;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (en_in) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][KERNEL-1] <= col_data[r];
      end
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL; c++) begin
        win_flat[(r*KERNEL+c)*N +: N] = win[r][c];
      end
    end
  end

  // The window settles on the accepting edge; it is published on the following edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      en_out    <= 1'b0;
      frame_end <= 1'b0;
      data2conv <= '0;
    end else begin
      valid_q   <= win_valid;
      last_q    <= win_valid && at_frame_end;
      en_out    <= valid_q;
      frame_end <= last_q;
      if (valid_q) begin
        data2conv <= win_flat;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Testbench for conv_window_gen: three instances (KERNEL 3, 1, 7) driven by one stream and
// compared every cycle against a position/image-array reference model.
module tb_conv_window_gen;

  localparam int MAXW = 7 * 7 * 8;

  typedef struct {
    logic            en;
    logic            fe;
    logic [MAXW-1:0] data;
    logic            acc;
    int              prow;
    int              pcol;
  } exp_t;

  typedef struct {
    int         prow;
    int         pcol;
    logic       exp_en;
    logic       exp_fe;
    logic [7:0] e0;
    logic [7:0] e4;
    logic [7:0] e8;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   pix_in;
  logic         en_in;
  logic         sof;
  logic [71:0]  data_k3;
  logic         en_k3, fe_k3;
  logic [7:0]   data_k1;
  logic         en_k1, fe_k1;
  logic [391:0] data_k7;
  logic         en_k7, fe_k7;

  always #5 clk = ~clk;

  conv_window_gen #(.KERNEL(3), .N(8), .IMG_W(6), .IMG_H(5)) u_k3 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .en_in(en_in), .sof(sof),
    .data2conv(data_k3), .en_out(en_k3), .frame_end(fe_k3));

  conv_window_gen #(.KERNEL(1), .N(8), .IMG_W(6), .IMG_H(5)) u_k1 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .en_in(en_in), .sof(sof),
    .data2conv(data_k1), .en_out(en_k1), .frame_end(fe_k1));

  conv_window_gen #(.KERNEL(7), .N(8), .IMG_W(8), .IMG_H(8)) u_k7 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .en_in(en_in), .sof(sof),
    .data2conv(data_k7), .en_out(en_k7), .frame_end(fe_k7));

  int              kk [3] = '{3, 1, 7};
  int              ww [3] = '{6, 6, 8};
  int              hh [3] = '{5, 5, 8};
  int              mrow [3];
  int              mcol [3];
  logic [7:0]      img [3][8][8];
  logic [MAXW-1:0] last_data [3];
  exp_t            d1 [3];
  exp_t            d2 [3];
  int              pulses [3];
  int              fends [3];
  int              n_cmp;
  int              n_err;
  logic            record_on;
  logic            obs_en [8][8];
  logic            obs_fe [8][8];
  logic [71:0]     obs_data [8][8];
  logic            k7_seen;
  logic [MAXW-1:0] k7_first;
  vec_t            vecs [7];

  task automatic check_val(input string name, input int d, input logic [MAXW-1:0] got,
                           input logic [MAXW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("[TB] FAIL %s (dut %0d): got %0h, expected %0h", name, d, got, want);
    end
  endtask

  task automatic get_out(input int d, output logic e, output logic f, output logic [MAXW-1:0] dat);
    case (d)
      0:       begin e = en_k3; f = fe_k3; dat = MAXW'(data_k3); end
      1:       begin e = en_k1; f = fe_k1; dat = MAXW'(data_k1); end
      default: begin e = en_k7; f = fe_k7; dat = MAXW'(data_k7); end
    endcase
  endtask

  task automatic clear_model();
    exp_t z;
    z.en = 1'b0; z.fe = 1'b0; z.data = '0; z.acc = 1'b0; z.prow = 0; z.pcol = 0;
    for (int d = 0; d < 3; d++) begin
      mrow[d] = 0;
      mcol[d] = 0;
      last_data[d] = '0;
      d1[d] = z;
      d2[d] = z;
    end
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 3; d++) begin
      pulses[d] = 0;
      fends[d] = 0;
    end
  endtask

  // Reference: remember every pixel at its raster position; a window is the KxK block ending there
  task automatic model_step(input int d, input logic en, input logic s, input logic [7:0] pix,
                            output exp_t x);
    int r, c, k;
    logic [MAXW-1:0] w;
    k = kk[d];
    x.en = 1'b0; x.fe = 1'b0; x.data = last_data[d]; x.acc = 1'b0; x.prow = 0; x.pcol = 0;
    if (en) begin
      r = s ? 0 : mrow[d];
      c = s ? 0 : mcol[d];
      img[d][r][c] = pix;
      x.acc = 1'b1; x.prow = r; x.pcol = c;
      if (r >= k - 1 && c >= k - 1) begin
        w = '0;
        for (int wr = 0; wr < k; wr++)
          for (int wc = 0; wc < k; wc++)
            w[(wr*k+wc)*8 +: 8] = img[d][r-k+1+wr][c-k+1+wc];
        x.en = 1'b1;
        x.fe = (r == hh[d] - 1) && (c == ww[d] - 1);
        x.data = w;
        last_data[d] = w;
      end
      c++;
      if (c == ww[d]) begin
        c = 0;
        r++;
        if (r == hh[d]) r = 0;
      end
      mrow[d] = r;
      mcol[d] = c;
    end
  endtask

  function automatic logic [7:0] pattern(input int d, input logic s);
    int r, c;
    r = s ? 0 : mrow[d];
    c = s ? 0 : mcol[d];
    return 8'(r * 16 + c);
  endfunction

  task automatic check_output(input int d);
    logic e, f;
    logic [MAXW-1:0] dat;
    get_out(d, e, f, dat);
    check_val("en_out", d, MAXW'(e), MAXW'(d2[d].en));
    check_val("frame_end", d, MAXW'(f), MAXW'(d2[d].fe));
    check_val("data2conv", d, dat, d2[d].data);
    if (e) pulses[d]++;
    if (f) fends[d]++;
    if (d == 0 && record_on && d2[0].acc) begin
      obs_en[d2[0].prow][d2[0].pcol] = e;
      obs_fe[d2[0].prow][d2[0].pcol] = f;
      obs_data[d2[0].prow][d2[0].pcol] = dat[71:0];
    end
    if (d == 2 && e && !k7_seen) begin
      k7_seen = 1'b1;
      k7_first = dat;
    end
  endtask

  // Outputs seen at a falling edge belong to the pixel driven two falling edges earlier
  task automatic apply_stimulus(input logic en, input logic s, input logic [7:0] pix);
    exp_t x;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check_output(d);
    for (int d = 0; d < 3; d++) begin
      d2[d] = d1[d];
      model_step(d, en, s, pix, x);
      d1[d] = x;
    end
    en_in = en;
    sof = s;
    pix_in = pix;
  endtask

  task automatic flush();
    apply_stimulus(1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_reset_outputs();
    logic e, f;
    logic [MAXW-1:0] dat;
    for (int d = 0; d < 3; d++) begin
      get_out(d, e, f, dat);
      check_val("reset en_out", d, MAXW'(e), '0);
      check_val("reset frame_end", d, MAXW'(f), '0);
      check_val("reset data2conv", d, dat, '0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) check_output(d);
    en_in = 1'b0;
    sof = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_outputs();
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int accepted;
    logic en, s;

    vecs[0] = '{2, 2, 1'b1, 1'b0, 8'h00, 8'h11, 8'h22};
    vecs[1] = '{2, 3, 1'b1, 1'b0, 8'h01, 8'h12, 8'h23};
    vecs[2] = '{3, 4, 1'b1, 1'b0, 8'h12, 8'h23, 8'h34};
    vecs[3] = '{4, 5, 1'b1, 1'b1, 8'h23, 8'h34, 8'h45};
    vecs[4] = '{2, 1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{1, 5, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[6] = '{4, 0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};

    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        obs_en[r][c] = 1'b0;
        obs_fe[r][c] = 1'b0;
        obs_data[r][c] = '0;
      end

    rst = 1'b0; en_in = 1'b0; sof = 1'b0; pix_in = 8'h00;
    n_cmp = 0; n_err = 0; record_on = 1'b0; k7_seen = 1'b0; k7_first = '0;
    clear_model();
    clear_counts();
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    $display("[TB] basic frame");
    record_on = 1'b1;
    for (int i = 0; i < 30; i++) apply_stimulus(1'b1, i == 0, pattern(0, i == 0));
    flush();
    record_on = 1'b0;
    check_val("basic k3 windows", 0, MAXW'(pulses[0]), MAXW'(12));
    check_val("basic k3 frame_end", 0, MAXW'(fends[0]), MAXW'(1));
    check_val("basic k1 windows", 1, MAXW'(pulses[1]), MAXW'(30));
    check_val("basic k7 windows", 2, MAXW'(pulses[2]), MAXW'(0));
    for (int i = 0; i < 7; i++) begin
      check_val($sformatf("vec%0d en_out", i), 0,
                MAXW'(obs_en[vecs[i].prow][vecs[i].pcol]), MAXW'(vecs[i].exp_en));
      if (vecs[i].exp_en) begin
        check_val($sformatf("vec%0d frame_end", i), 0,
                  MAXW'(obs_fe[vecs[i].prow][vecs[i].pcol]), MAXW'(vecs[i].exp_fe));
        check_val($sformatf("vec%0d elem0", i), 0,
                  MAXW'(obs_data[vecs[i].prow][vecs[i].pcol][7:0]), MAXW'(vecs[i].e0));
        check_val($sformatf("vec%0d elem4", i), 0,
                  MAXW'(obs_data[vecs[i].prow][vecs[i].pcol][39:32]), MAXW'(vecs[i].e4));
        check_val($sformatf("vec%0d elem8", i), 0,
                  MAXW'(obs_data[vecs[i].prow][vecs[i].pcol][71:64]), MAXW'(vecs[i].e8));
      end
    end

    $display("[TB] random gaps");
    clear_counts();
    accepted = 0;
    for (int i = 0; i < 400 && accepted < 30; i++) begin
      en = 1'($urandom % 2);
      s = en && (accepted == 0);
      apply_stimulus(en, s, pattern(0, s));
      if (en) accepted++;
    end
    flush();
    check_val("gaps k3 windows", 0, MAXW'(pulses[0]), MAXW'(12));
    check_val("gaps k3 frame_end", 0, MAXW'(fends[0]), MAXW'(1));

    $display("[TB] mid-frame restart");
    for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b0, pattern(0, 1'b0));
    apply_stimulus(1'b1, 1'b1, pattern(0, 1'b1));
    clear_counts();
    for (int i = 0; i < 29; i++) apply_stimulus(1'b1, 1'b0, pattern(0, 1'b0));
    flush();
    check_val("restart k3 windows", 0, MAXW'(pulses[0]), MAXW'(12));
    check_val("restart k3 frame_end", 0, MAXW'(fends[0]), MAXW'(1));

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b0, pattern(0, 1'b0));
    do_reset();
    clear_counts();
    for (int i = 0; i < 30; i++) apply_stimulus(1'b1, 1'b0, pattern(0, 1'b0));
    flush();
    check_val("post-reset k3 windows", 0, MAXW'(pulses[0]), MAXW'(12));
    check_val("post-reset k3 frame_end", 0, MAXW'(fends[0]), MAXW'(1));

    $display("[TB] back-to-back frames");
    clear_counts();
    record_on = 1'b1;
    for (int i = 0; i < 60; i++) apply_stimulus(1'b1, i == 0, pattern(0, i == 0));
    flush();
    record_on = 1'b0;
    check_val("b2b k3 windows", 0, MAXW'(pulses[0]), MAXW'(24));
    check_val("b2b k3 frame_end", 0, MAXW'(fends[0]), MAXW'(2));
    check_val("b2b frame2 first en", 0, MAXW'(obs_en[2][2]), MAXW'(1));
    check_val("b2b frame2 first elem8", 0, MAXW'(obs_data[2][2][71:64]), MAXW'(8'h22));

    $display("[TB] random pixels");
    for (int i = 0; i < 400; i++) begin
      en = ($urandom % 4) != 0;
      s = ($urandom % 40) == 0;
      apply_stimulus(en, s, 8'($urandom));
    end
    flush();

    $display("[TB] kernel 7 frame");
    do_reset();
    clear_counts();
    k7_seen = 1'b0;
    for (int i = 0; i < 64; i++) apply_stimulus(1'b1, 1'b0, pattern(2, 1'b0));
    flush();
    check_val("k7 windows", 2, MAXW'(pulses[2]), MAXW'(4));
    check_val("k7 frame_end", 2, MAXW'(fends[2]), MAXW'(1));
    check_val("k1 windows", 1, MAXW'(pulses[1]), MAXW'(64));
    check_val("k7 first seen", 2, MAXW'(k7_seen), MAXW'(1));
    check_val("k7 first elem0", 2, MAXW'(k7_first[7:0]), MAXW'(8'h00));
    check_val("k7 first elem48", 2, MAXW'(k7_first[48*8 +: 8]), MAXW'(8'h66));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming sliding-window generator sitting directly upstream of the convolution calculation stage. It accepts one raster-scan pixel per enabled cycle and buffers KERNEL-1 image lines. For every valid (unpadded, stride-1) window position it presents the full KERNEL×KERNEL pixel window on `data2conv` with a one-cycle `en_out` strobe. The window packing and enable semantics match the conv stage's `data2conv`/`en_in` inputs, so the two connect directly.

## Interface

Parameters:
- `KERNEL`, 3 — window side; legal values 1/3/5/7.
- `N`, 8 — pixel width in bits, carried through unmodified.
- `IMG_W`, 28 — pixels per image line; must be ≥ KERNEL.
- `IMG_H`, 28 — lines per frame; must be ≥ KERNEL.

Ports:
- `clk`  in  1  — single clock; all logic on rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `pix_in`  in  N  — input pixel, raster order (left→right, top→bottom).
- `en_in`  in  1  — `pix_in` valid this cycle; no backpressure.
- `sof`  in  1  — start of frame; meaningful only when `en_in`=1.
- `data2conv`  out  KERNEL*KERNEL*N  — packed window.
- `en_out`  out  1  — `data2conv` valid this cycle; feeds the conv stage's `en_in`.
- `frame_end`  out  1  — pulses together with `en_out` for the last window of a frame.

## Operation

- **Counters.**
  - `col` runs 0..IMG_W-1 and `row` runs 0..IMG_H-1. Both advance only on `en_in`=1.
  - `col` wraps to 0 and `row` increments at IMG_W-1.
  - After pixel (IMG_H-1, IMG_W-1) both counters return to 0; the next pixel is the start of a new frame without needing `sof`.
- **sof.**
  - `en_in`=1 with `sof`=1: the current pixel is treated as (0,0) and the counters continue from there. This applies mid-frame too (restart); the abandoned partial frame emits no further windows.
  - `sof` with `en_in`=0 is ignored.
- **Line buffers.**
  - KERNEL-1 circular buffers of IMG_W×N bits each, indexed by `col`.
  - Each accepted pixel is written at `col`; the older lines shift down one buffer at the same address.
  - Buffer contents are not reset.
- **Window register.**
  - KERNEL×KERNEL registers. On each accepted pixel every window row shifts left by one column.
  - The rightmost column is loaded from the line buffers at `col` (older lines) plus `pix_in` (bottom row).
- **Packing.**
  - Element index i = r*KERNEL + c, where r=0 is the top (oldest) line and c=0 is the leftmost (oldest) column.
  - Element i is placed at `data2conv[i*N +: N]`, so element KERNEL*KERNEL-1 is the newest pixel.
- **Valid rule.** An accepted pixel at (row, col) with row ≥ KERNEL-1 and col ≥ KERNEL-1 produces exactly one window. That window's bottom-right pixel is the accepted pixel.
- **Window count.** Windows per frame = (IMG_W-KERNEL+1)*(IMG_H-KERNEL+1). Windows never straddle a line wrap: the valid rule gates them out.
- **KERNEL=1.** No line buffers are used. Every pixel produces a window (`data2conv` = pixel).
- **frame_end.** Asserted with `en_out` when the producing pixel was (IMG_H-1, IMG_W-1).

## Timing

- **Reset values.**
  - While `rst`=0: `data2conv`=0, `en_out`=0, `frame_end`=0, `col`=0, `row`=0, window registers 0.
  - Reset takes effect immediately (asynchronous), including mid-frame. The first pixel after release is (0,0).
- **Latency.** Exactly 1 cycle. The pixel accepted at edge k yields `en_out`=1 and a valid `data2conv` after edge k+1.
- **Strobe width.** `en_out` is high for one cycle per window.
- **Output hold.** `data2conv` holds its last value while `en_out`=0.
- **Gaps in en_in.** Any number of idle cycles is allowed. All state holds; the output stream is identical to the gap-free stream, only delayed.
- **Back-to-back.** With `en_in` held high, `en_out` is high on consecutive cycles along each valid row segment.

## Test plan

- **Basic frame.** KERNEL=3, IMG_W=6, IMG_H=5, `pix_in`=row*16+col, `en_in` continuous with `sof` on the first pixel.
  - Expect 12 `en_out` pulses.
  - First pulse one cycle after pixel 0x22; its elements 0, 4, 8 are 0x00, 0x11, 0x22.
  - Last window element 8 is 0x45, with `frame_end`=1.
- **Random gaps.** Same frame with pseudo-random `en_in` gaps (~50% duty). Expect the same 12 windows in the same order and with the same contents; each `en_out` comes exactly 1 cycle after its producing pixel.
- **Mid-frame restart.** Assert `sof` at pixel (3,2), then stream a full frame. Expect no windows from the abandoned frame after the `sof` pixel, then 12 correct windows with `frame_end` on the last one.
- **Reset mid-frame.** Drive `rst` low during row 3. Expect `en_out`, `frame_end` and `data2conv` to read 0 immediately. After release, a full frame yields 12 correct windows.
- **Back-to-back frames.** Two frames without `sof` on the second. Expect 24 windows and two `frame_end` pulses; the second frame's first window (element 8) is 0x22 of frame 2.
- **KERNEL=1 and KERNEL=7.**
  - KERNEL=1 on a 6×5 frame: 30 windows, each equal to its pixel, 1-cycle latency.
  - KERNEL=7, IMG_W=IMG_H=8: 4 windows; the first has element 0 = 0x00 and element 48 = 0x66.
